// File: rtl/dmem_io_resp_pkg.sv
// dmem_io_resp_pkg
// Shared constants for the data-memory I/O responder: register offsets
// inside the 4 KiB window, CTRL bit positions and the window width.
package dmem_io_resp_pkg;

  localparam int IO_WIN_BITS = 12;

  localparam logic [IO_WIN_BITS-1:0] IO_SEG     = 12'h000;
  localparam logic [IO_WIN_BITS-1:0] IO_SCRATCH = 12'h004;
  localparam logic [IO_WIN_BITS-1:0] IO_COUNT   = 12'h008;
  localparam logic [IO_WIN_BITS-1:0] IO_CMP     = 12'h00C;
  localparam logic [IO_WIN_BITS-1:0] IO_CTRL    = 12'h010;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_FLAG = 3;

endpackage

// File: rtl/dmem_io_timer.sv
// dmem_io_timer
// Prescaled compare timer: COUNT, CMP and CTRL registers, match detect and
// sticky FLAG with write-1-to-clear.
// Ports:
//   m_clock, p_reset            clock, async active-high reset
//   count_we, cmp_we, ctrl_we   one-cycle register write strobes
//   wdata                       write data from the bus
//   count, cmp, ctrl            register values for the read mux
//   timer_irq                   FLAG & IE
module dmem_io_timer
  import dmem_io_resp_pkg::*;
#(
  parameter int TIMER_DIV = 1
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic [31:0] ctrl,
  output logic        timer_irq
);

  localparam logic [31:0] DIV_LAST = 32'(TIMER_DIV - 1);

  logic [31:0] presc;
  logic        en, auto_rl, ie, flag;
  logic        tick, match;

  assign tick  = en && (presc == DIV_LAST);
  // Match looks at the pre-increment, pre-write COUNT.
  assign match = tick && (count == cmp);

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      presc   <= '0;
      count   <= '0;
      cmp     <= '0;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      flag    <= 1'b0;
    end else begin
      if (ctrl_we && !wdata[CTRL_EN])
        presc <= '0;
      else if (en)
        presc <= tick ? '0 : presc + 32'd1;

      // Software write beats increment and reload.
      if (count_we)
        count <= wdata;
      else if (tick)
        count <= (match && auto_rl) ? '0 : count + 32'd1;

      if (cmp_we)
        cmp <= wdata;

      if (ctrl_we) begin
        en      <= wdata[CTRL_EN];
        auto_rl <= wdata[CTRL_AUTO];
        ie      <= wdata[CTRL_IE];
      end

      // Hardware set wins over a same-cycle clear.
      if (match)
        flag <= 1'b1;
      else if (ctrl_we && wdata[CTRL_FLAG])
        flag <= 1'b0;
    end
  end

  assign ctrl      = {28'd0, flag, ie, auto_rl, en};
  assign timer_irq = flag & ie;

endmodule

// File: rtl/dmem_io_resp.sv
// dmem_io_resp
// Memory-mapped I/O responder on the data-memory bus. Decodes a 4 KiB window
// at BASE_ADDR, returns read data one cycle after a hit read (read-before-
// write on simultaneous access) and holds SEG, SCRATCH and, when the macro
// DMEM_IO_TIMER_EN is defined, the compare timer registers.
// Ports:
//   m_clock, p_reset        clock, async active-high reset
//   dmem_read, dmem_write   bus strobes
//   daddr, wdata            byte address (word aligned), write data
//   rdata, io_hit           registered read data and hit flag
//   seg_data                SEG register
//   timer_irq               timer interrupt (0 without DMEM_IO_TIMER_EN)
module dmem_io_resp
  import dmem_io_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
  parameter int          TIMER_DIV = 1
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] daddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        io_hit,
  output logic [31:0] seg_data,
  output logic        timer_irq
);

  logic                   hit;
  logic [IO_WIN_BITS-1:0] off;
  logic                   wr;
  logic [31:0]            scratch;
  logic [31:0]            rd_val;
  logic [31:0]            tmr_count, tmr_cmp, tmr_ctrl;
  logic                   unused_addr_bits;

  assign hit = (daddr[31:IO_WIN_BITS] == BASE_ADDR[31:IO_WIN_BITS]);
  assign off = {daddr[IO_WIN_BITS-1:2], 2'b00};
  assign wr  = dmem_write && hit;
  assign unused_addr_bits = ^daddr[1:0];

`ifdef DMEM_IO_TIMER_EN
  dmem_io_timer #(.TIMER_DIV(TIMER_DIV)) u_timer (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .count_we (wr && (off == IO_COUNT)),
    .cmp_we   (wr && (off == IO_CMP)),
    .ctrl_we  (wr && (off == IO_CTRL)),
    .wdata    (wdata),
    .count    (tmr_count),
    .cmp      (tmr_cmp),
    .ctrl     (tmr_ctrl),
    .timer_irq(timer_irq)
  );
`else
  localparam int unused_timer_div = TIMER_DIV;
  assign tmr_count = '0;
  assign tmr_cmp   = '0;
  assign tmr_ctrl  = '0;
  assign timer_irq = 1'b0;
`endif

  // Read mux sees current register values, giving read-before-write.
  always_comb begin
    rd_val = '0;
    case (off)
      IO_SEG:     rd_val = seg_data;
      IO_SCRATCH: rd_val = scratch;
      IO_COUNT:   rd_val = tmr_count;
      IO_CMP:     rd_val = tmr_cmp;
      IO_CTRL:    rd_val = tmr_ctrl;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      seg_data <= '0;
      scratch  <= '0;
      rdata    <= '0;
      io_hit   <= 1'b0;
    end else begin
      if (wr && (off == IO_SEG))
        seg_data <= wdata;
      if (wr && (off == IO_SCRATCH))
        scratch <= wdata;
      io_hit <= dmem_read && hit;
      rdata  <= (dmem_read && hit) ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_dmem_io_resp.sv
module tb_dmem_io_resp;

  localparam logic [31:0] BASE = 32'hFFFF_F000;
  localparam int          TDIV = 1;
`ifdef DMEM_IO_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic        m_clock = 1'b0;
  logic        p_reset;
  logic        dmem_read, dmem_write;
  logic [31:0] daddr, wdata;
  logic [31:0] rdata, seg_data;
  logic        io_hit, timer_irq;

  dmem_io_resp #(.BASE_ADDR(BASE), .TIMER_DIV(TDIV)) dut (
    .m_clock(m_clock), .p_reset(p_reset),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .daddr(daddr), .wdata(wdata),
    .rdata(rdata), .io_hit(io_hit),
    .seg_data(seg_data), .timer_irq(timer_irq)
  );

  always #5 m_clock = ~m_clock;

  typedef struct {
    logic        hit;
    logic [31:0] rdata;
    logic [31:0] seg;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference state, one variable per architectural register
  logic [31:0] m_seg, m_scr, m_count, m_cmp, m_presc;
  bit          m_en, m_auto, m_ie, m_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seg = 0; m_scr = 0; m_count = 0; m_cmp = 0; m_presc = 0;
    m_en = 0; m_auto = 0; m_ie = 0; m_flag = 0;
  endtask

  function automatic logic [31:0] mread(input logic [11:0] off);
    if (off == 12'h000) return m_seg;
    if (off == 12'h004) return m_scr;
    if (TIMER_ON && off == 12'h008) return m_count;
    if (TIMER_ON && off == 12'h00C) return m_cmp;
    if (TIMER_ON && off == 12'h010) return {28'd0, m_flag, m_ie, m_auto, m_en};
    return 32'd0;
  endfunction

  // One bus cycle: drive at negedge, predict the post-edge state, queue it.
  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit hit, tick, match, flag_n;
    logic [11:0] off;
    logic [31:0] count_n, presc_n;
    @(negedge m_clock);
    dmem_read = rd; dmem_write = wr; daddr = a; wdata = d;
    hit = (a[31:12] == BASE[31:12]);
    off = {a[11:2], 2'b00};
    e.hit   = rd && hit;
    e.rdata = (rd && hit) ? mread(off) : 32'd0;
    tick  = TIMER_ON && m_en && (m_presc == TDIV - 1);
    match = tick && (m_count == m_cmp);
    count_n = m_count;
    presc_n = m_presc;
    flag_n  = m_flag;
    if (m_en) presc_n = tick ? 32'd0 : m_presc + 1;
    if (tick) count_n = (match && m_auto) ? 32'd0 : m_count + 1;
    if (wr && hit) begin
      if (off == 12'h000) m_seg = d;
      if (off == 12'h004) m_scr = d;
      if (TIMER_ON && off == 12'h008) count_n = d;
      if (TIMER_ON && off == 12'h00C) m_cmp = d;
      if (TIMER_ON && off == 12'h010) begin
        m_en = d[0]; m_auto = d[1]; m_ie = d[2];
        if (d[3]) flag_n = 0;
        if (!d[0]) presc_n = 0;
      end
    end
    if (match) flag_n = 1;
    m_count = count_n;
    m_presc = presc_n;
    m_flag  = flag_n;
    e.seg = m_seg;
    e.irq = m_flag & m_ie;
    q.push_back(e);
  endtask

  always @(posedge m_clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("io_hit", {31'd0, io_hit}, {31'd0, e.hit});
      chk("rdata", rdata, e.rdata);
      chk("seg_data", seg_data, e.seg);
      chk("timer_irq", {31'd0, timer_irq}, {31'd0, e.irq});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    p_reset = 1'b1;
    dmem_read = 0; dmem_write = 0; daddr = 0; wdata = 0;
    model_reset();
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_io_hit", {31'd0, io_hit}, 32'd0);
    chk("reset_seg", seg_data, 32'd0);
    chk("reset_irq", {31'd0, timer_irq}, 32'd0);
    repeat (2) @(negedge m_clock);
    p_reset = 1'b0;

    // SEG write then read back
    drive(0, 1, BASE + 32'h00, 32'h0012_3456);
    drive(1, 0, BASE + 32'h00, 32'h0);
    drive(0, 0, 32'h0, 32'h0);

    // read-before-write on SCRATCH
    drive(0, 1, BASE + 32'h04, 32'hA5A5_A5A5);
    drive(1, 1, BASE + 32'h04, 32'h5A5A_5A5A);
    drive(1, 0, BASE + 32'h04, 32'h0);

    // auto-reload compare at 5 with interrupt, then W1C
    drive(0, 1, BASE + 32'h0C, 32'd5);
    drive(0, 1, BASE + 32'h08, 32'd0);
    drive(0, 1, BASE + 32'h10, 32'h7);
    for (int i = 0; i < 10; i++) drive(1, 0, BASE + 32'h08, 32'h0);
    drive(1, 0, BASE + 32'h10, 32'h0);
    drive(0, 1, BASE + 32'h10, 32'hF);
    drive(1, 0, BASE + 32'h10, 32'h0);

    // free-running wrap past 2^32 with CMP=0, AUTO=0
    drive(0, 1, BASE + 32'h10, 32'h0);
    drive(0, 1, BASE + 32'h0C, 32'h0);
    drive(0, 1, BASE + 32'h08, 32'hFFFF_FFFE);
    drive(0, 1, BASE + 32'h10, 32'h5);
    for (int i = 0; i < 5; i++) drive(1, 0, BASE + 32'h08, 32'h0);

    // outside the window and unmapped offset
    drive(1, 0, 32'h0000_0200, 32'h0);
    drive(1, 0, BASE + 32'h40, 32'h0);
    drive(0, 1, BASE + 32'h40, 32'hDEAD_BEEF);
    drive(0, 1, 32'h0000_0000, 32'h1111_1111);
    drive(1, 0, BASE + 32'h00, 32'h0);

    // asynchronous reset mid-count
    @(negedge m_clock);
    dmem_read = 0; dmem_write = 0;
    p_reset = 1'b1;
    #1;
    chk("async_rst_rdata", rdata, 32'd0);
    chk("async_rst_io_hit", {31'd0, io_hit}, 32'd0);
    chk("async_rst_seg", seg_data, 32'd0);
    chk("async_rst_irq", {31'd0, timer_irq}, 32'd0);
    model_reset();
    @(negedge m_clock);
    p_reset = 1'b0;
    drive(1, 0, BASE + 32'h08, 32'h0);
    drive(1, 0, BASE + 32'h10, 32'h0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      int sel;
      logic [31:0] a, d;
      sel = $urandom_range(0, 7);
      if (sel <= 4)      a = BASE + 32'(sel * 4);
      else if (sel == 5) a = BASE + 32'h40;
      else if (sel == 6) a = 32'h0000_0200;
      else               a = BASE + {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
    end

    drive(0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge m_clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_io_resp.md
# dmem_io_resp

Memory-mapped I/O responder on the core's data-memory bus (`dmem_read`/`dmem_write`/`daddr`/`wdata`/`rdata`), sitting beside the data RAM in the top level. Decodes a 4 KiB I/O window and services it with single-cycle-latency reads, matching the synchronous RAM. Holds the 7-segment display data register, a scratch/status register and a compare timer with an interrupt flag. The top level muxes `rdata` from this block or the RAM using `io_hit`.

## Interface
- `BASE_ADDR`, default 32'hFFFF_F000: I/O window base; window is `daddr[31:12] == BASE_ADDR[31:12]`.
- `TIMER_DIV`, default 1: timer ticks once every `TIMER_DIV` cycles (≥1).
- `m_clock` in 1: sole clock, rising edge.
- `p_reset` in 1: asynchronous, active-high reset.
- `dmem_read` in 1: read strobe from core.
- `dmem_write` in 1: write strobe from core.
- `daddr` in 32: byte address; `[1:0]` ignored (word access only).
- `wdata` in 32: write data.
- `rdata` out 32: registered read data, valid the cycle after a hit read.
- `io_hit` out 1: registered; 1 the cycle after a read that hit the window. Top uses it as RAM/IO mux select.
- `seg_data` out 32: SEG register contents, to the 7-segment controller.
- `timer_irq` out 1: level, equals CTRL.FLAG & CTRL.IE.

## Operation
- Register map (offset from BASE_ADDR):
  - 0x00 SEG: RW, 32 bit, drives `seg_data`.
  - 0x04 SCRATCH: RW, 32 bit.
  - 0x08 COUNT: RW, 32-bit timer count.
  - 0x0C CMP: RW, 32-bit compare value.
  - 0x10 CTRL: bit0 EN, bit1 AUTO (reload on match), bit2 IE, bit3 FLAG. FLAG is RO set, write-1-to-clear. Other bits read 0.
- Unmapped offsets inside the window read 0; writes to them are ignored.
- Accesses outside the window are ignored. `io_hit` and `rdata` are 0 the following cycle.
- Read and write asserted in the same cycle at a hit address:
  - the write commits;
  - `rdata` returns the pre-write value (read-before-write).
- Timer:
  - Prescaler counts 0..TIMER_DIV-1 while EN=1 and emits one tick at wrap.
  - On each tick, COUNT increments modulo 2^32.
  - EN=0 freezes COUNT and the prescaler. Prescaler clears when EN is written 0.
- Match: on a tick where pre-increment COUNT == CMP:
  - FLAG sets;
  - COUNT loads 0 if AUTO=1, otherwise increments normally.
- Priorities:
  - A software write to COUNT overrides increment/reload in that cycle; match is still evaluated on the pre-write COUNT.
  - FLAG set and W1C in the same cycle: set wins.

## Timing
- Reset values:
  - all registers 0;
  - `rdata`=0, `io_hit`=0, `seg_data`=0, `timer_irq`=0;
  - prescaler 0.
- Read latency is exactly 1 cycle. `rdata`/`io_hit` update every cycle; there is no hold beyond one cycle.
- A write takes effect on the strobe edge. A read of the same register in the next cycle returns the new value.
- `timer_irq` rises the cycle after the matching tick edge and falls the cycle after the W1C write.
- Reset asserted mid-operation clears everything immediately (asynchronous). No access in flight survives reset.

## Configuration
- `DMEM_IO_TIMER_EN` defined: timer, COUNT/CMP/CTRL registers and `timer_irq` are present as above.
- `DMEM_IO_TIMER_EN` undefined:
  - offsets 0x08–0x10 behave as unmapped (read 0, writes ignored);
  - `timer_irq` is tied 0;
  - no timer logic is synthesized.

## Structure
- Shared package holds:
  - register offset constants (`IO_SEG`, `IO_SCRATCH`, `IO_COUNT`, `IO_CMP`, `IO_CTRL`);
  - CTRL bit-position constants;
  - window size constant (12 address bits).
- One sub-module `dmem_io_timer`: prescaler, COUNT, CMP, CTRL, match and FLAG logic. It takes write strobes and data from the decoder and returns register values for the read mux. It is instantiated only under `DMEM_IO_TIMER_EN`.

## Test plan
- Reset, then write 0x00123456 to BASE+0x00 → `seg_data`=0x00123456 next cycle. A read of BASE+0x00 gives `rdata`=0x00123456 and `io_hit`=1 one cycle later.
- Simultaneous read+write of SCRATCH: old value 0xA5A5A5A5, write 0x5A5A5A5A → `rdata`=0xA5A5A5A5. The next read returns 0x5A5A5A5A.
- TIMER_DIV=1, CMP=5, CTRL=EN|AUTO|IE → FLAG and `timer_irq`=1 one cycle after the tick where COUNT==5. COUNT then reads 0,1,2… Writing CTRL with bit3=1 clears the IRQ next cycle.
- AUTO=0, COUNT written 0xFFFFFFFE, CMP=0 → COUNT wraps to 0 without FLAG. FLAG sets at the following tick (COUNT==0).
- Read outside the window (0x00000200) and read of unmapped BASE+0x40 → the first gives `io_hit`=0 and `rdata`=0. The second gives `io_hit`=1 and `rdata`=0.
- Assert `p_reset` mid-count with `timer_irq`=1 → all outputs 0 immediately. COUNT reads 0 after release.
